// File: rtl/demux_frame_assembler_if.sv
// Handshake and demux bundle shared by the frame assembler and its environment.
// The assembler uses the slave modport; the serial source, consumer and demux sit on master.
interface demux_frame_assembler_if #(
  parameter int SEL_W = 3
);
  localparam int CH = 1 << SEL_W;

  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic             sync;
  logic             dmx_i;
  logic [SEL_W-1:0] dmx_sel;
  logic [CH-1:0]    dmx_y;
  logic [CH-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             sync_err;

  modport master (
    output in_bit, in_valid, sync, dmx_y, out_ready,
    input  in_ready, dmx_i, dmx_sel, out_data, out_valid, sync_err
  );

  modport slave (
    input  in_bit, in_valid, sync, dmx_y, out_ready,
    output in_ready, dmx_i, dmx_sel, out_data, out_valid, sync_err
  );
endinterface

// File: rtl/demux_frame_assembler.sv
// Serial-to-parallel frame assembler: steers each accepted bit through an external 1:8 demux
// and ORs the demux outputs into a frame, presented through a one-frame holding slot.
module demux_frame_assembler #(
  parameter int SEL_W     = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demux_frame_assembler_if.slave  bus
);
  localparam int                CH       = 1 << SEL_W;
  localparam logic [SEL_W-1:0]  LAST_POS = SEL_W'(CH - 1);

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;

  slot_e            slot_q, slot_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [CH-1:0]    asm_q, asm_d;
  logic [CH-1:0]    out_data_q, out_data_d;
  logic             sync_err_q, sync_err_d;

  logic [SEL_W-1:0] pos;
  logic [CH-1:0]    asm_base;
  logic             slot_full;
  logic             stall;
  logic             acc;

  // A sync forces the current bit to position 0 and discards the partial frame.
  always_comb begin
    pos       = bus.sync ? '0 : ch_q;
    asm_base  = bus.sync ? '0 : asm_q;
    slot_full = (slot_q == SLOT_FULL);
    stall     = (pos == LAST_POS) && slot_full && !bus.out_ready;
    acc       = bus.in_valid && rst_n && !stall;
  end

  assign bus.in_ready  = rst_n & ~stall;
  assign bus.dmx_sel   = MSB_FIRST ? (LAST_POS - pos) : pos;
  assign bus.dmx_i     = bus.in_bit & acc;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = slot_full;
  assign bus.sync_err  = sync_err_q;

  always_comb begin
    ch_d       = ch_q;
    asm_d      = asm_q;
    out_data_d = out_data_q;
    slot_d     = slot_q;
    sync_err_d = bus.sync && (ch_q != '0);

    if (slot_full && bus.out_ready) begin
      slot_d = SLOT_EMPTY;
    end

    // A frame completing in the same cycle as a drain refills the slot directly.
    if (acc) begin
      if (pos == LAST_POS) begin
        out_data_d = asm_base | bus.dmx_y;
        slot_d     = SLOT_FULL;
        asm_d      = '0;
        ch_d       = '0;
      end else begin
        asm_d = asm_base | bus.dmx_y;
        ch_d  = pos + SEL_W'(1);
      end
    end else if (bus.sync) begin
      asm_d = '0;
      ch_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= SLOT_EMPTY;
      ch_q       <= '0;
      asm_q      <= '0;
      out_data_q <= '0;
      sync_err_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      ch_q       <= ch_d;
      asm_q      <= asm_d;
      out_data_q <= out_data_d;
      sync_err_q <= sync_err_d;
    end
  end
endmodule

// File: tb/tb_demux_frame_assembler.sv
// Directed bench for demux_frame_assembler: an LSB-first and an MSB-first instance share one
// stimulus stream, each wired to a behavioural 1:8 demux.
module tb_demux_frame_assembler;
  logic clk = 1'b0;
  logic rst_n;
  logic in_bit;
  logic in_valid;
  logic sync;
  logic out_ready;

  int checks   = 0;
  int failures = 0;

  demux_frame_assembler_if #(.SEL_W(3)) bus0 ();
  demux_frame_assembler_if #(.SEL_W(3)) bus1 ();

  assign bus0.in_bit    = in_bit;
  assign bus0.in_valid  = in_valid;
  assign bus0.sync      = sync;
  assign bus0.out_ready = out_ready;
  assign bus0.dmx_y     = bus0.dmx_i ? (8'h01 << bus0.dmx_sel) : 8'h00;

  assign bus1.in_bit    = in_bit;
  assign bus1.in_valid  = in_valid;
  assign bus1.sync      = sync;
  assign bus1.out_ready = out_ready;
  assign bus1.dmx_y     = bus1.dmx_i ? (8'h01 << bus1.dmx_sel) : 8'h00;

  demux_frame_assembler #(.SEL_W(3), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  demux_frame_assembler #(.SEL_W(3), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  // Present one bit at the falling edge and return just after the rising edge that takes it.
  task automatic send_bit(input logic b);
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = b;
    sync     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
    sync     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    sync      = 1'b0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus0.out_valid);
    end
    checks++;
    if (bus0.out_data !== 8'h00) begin
      failures++; $display("[TB] FAIL reset_out_data: got %h expected 00", bus0.out_data);
    end
    checks++;
    if (bus0.in_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus0.in_ready);
    end
    checks++;
    if (bus0.sync_err !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_sync_err: got %b expected 0", bus0.sync_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus0.in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL release_in_ready: got %b expected 1", bus0.in_ready);
    end
  endtask

  task automatic test_bit_order();
    logic [7:0] stream;
    stream    = 8'h0F;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = stream[i];
      sync     = 1'b0;
      #1;
      checks++;
      if (bus0.dmx_sel !== 3'(i)) begin
        failures++; $display("[TB] FAIL lsb_sel bit %0d: got %0d expected %0d", i, bus0.dmx_sel, i);
      end
      checks++;
      if (bus1.dmx_sel !== 3'(7 - i)) begin
        failures++; $display("[TB] FAIL msb_sel bit %0d: got %0d expected %0d", i, bus1.dmx_sel, 7 - i);
      end
      checks++;
      if (bus0.dmx_i !== stream[i]) begin
        failures++; $display("[TB] FAIL dmx_i bit %0d: got %b expected %b", i, bus0.dmx_i, stream[i]);
      end
      @(posedge clk);
      #1;
      if (i < 7) begin
        checks++;
        if (bus0.out_valid !== 1'b0) begin
          failures++; $display("[TB] FAIL early_valid bit %0d: got %b expected 0", i, bus0.out_valid);
        end
      end
    end
    checks++;
    if (bus0.out_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL order_valid: got %b expected 1", bus0.out_valid);
    end
    checks++;
    if (bus0.out_data !== 8'h0F) begin
      failures++; $display("[TB] FAIL lsb_data: got %h expected 0f", bus0.out_data);
    end
    checks++;
    if (bus1.out_data !== 8'hF0) begin
      failures++; $display("[TB] FAIL msb_data: got %h expected f0", bus1.out_data);
    end
    idle();
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL order_drain: got %b expected 0", bus0.out_valid);
    end
  endtask

  task automatic test_holding_slot();
    logic [7:0] f1;
    logic [7:0] f2;
    f1        = 8'hA5;
    f2        = 8'h3C;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(f1[i]);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'hA5) begin
      failures++; $display("[TB] FAIL hold_first: got v=%b d=%h expected v=1 d=a5", bus0.out_valid, bus0.out_data);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = f2[i];
      #1;
      checks++;
      if (bus0.in_ready !== 1'b1) begin
        failures++; $display("[TB] FAIL hold_ready bit %0d: got %b expected 1", i, bus0.in_ready);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    in_bit = f2[7];
    #1;
    checks++;
    if (bus0.in_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL hold_stall: got %b expected 0", bus0.in_ready);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'hA5) begin
      failures++; $display("[TB] FAIL hold_keep: got v=%b d=%h expected v=1 d=a5", bus0.out_valid, bus0.out_data);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (bus0.in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL hold_unstall: got %b expected 1", bus0.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'h3C) begin
      failures++; $display("[TB] FAIL hold_second: got v=%b d=%h expected v=1 d=3c", bus0.out_valid, bus0.out_data);
    end
    idle();
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL hold_drain: got %b expected 0", bus0.out_valid);
    end
  endtask

  task automatic test_sync_abort();
    logic [7:0] f;
    f         = 8'h81;
    out_ready = 1'b1;
    repeat (3) send_bit(1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    sync     = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus0.sync_err !== 1'b1) begin
      failures++; $display("[TB] FAIL abort_pulse: got %b expected 1", bus0.sync_err);
    end
    @(negedge clk);
    sync = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus0.sync_err !== 1'b0) begin
      failures++; $display("[TB] FAIL abort_pulse_end: got %b expected 0", bus0.sync_err);
    end
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'h81) begin
      failures++; $display("[TB] FAIL abort_frame: got v=%b d=%h expected v=1 d=81", bus0.out_valid, bus0.out_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    sync     = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus0.sync_err !== 1'b0) begin
      failures++; $display("[TB] FAIL idle_sync_pulse: got %b expected 0", bus0.sync_err);
    end
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic test_sync_with_accept();
    logic [7:0] pre;
    logic [7:0] f;
    pre       = 8'h15;
    f         = 8'h81;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(pre[i]);
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = f[0];
    sync     = 1'b1;
    #1;
    checks++;
    if (bus0.dmx_sel !== 3'd0) begin
      failures++; $display("[TB] FAIL sync_acc_lsb_sel: got %0d expected 0", bus0.dmx_sel);
    end
    checks++;
    if (bus1.dmx_sel !== 3'd7) begin
      failures++; $display("[TB] FAIL sync_acc_msb_sel: got %0d expected 7", bus1.dmx_sel);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus0.sync_err !== 1'b1) begin
      failures++; $display("[TB] FAIL sync_acc_pulse: got %b expected 1", bus0.sync_err);
    end
    for (int i = 1; i < 8; i++) send_bit(f[i]);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'h81) begin
      failures++; $display("[TB] FAIL sync_acc_frame: got v=%b d=%h expected v=1 d=81", bus0.out_valid, bus0.out_data);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [7:0] f1;
    logic [7:0] f2;
    f1        = 8'h12;
    f2        = 8'h55;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(f1[i]);
    repeat (4) send_bit(1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.out_data !== 8'h00) begin
      failures++; $display("[TB] FAIL midreset_out: got v=%b d=%h expected v=0 d=00", bus0.out_valid, bus0.out_data);
    end
    checks++;
    if (bus0.in_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_in_ready: got %b expected 0", bus0.in_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(f2[i]);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_partial: got %b expected 0", bus0.out_valid);
    end
    send_bit(f2[7]);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'h55) begin
      failures++; $display("[TB] FAIL midreset_frame: got v=%b d=%h expected v=1 d=55", bus0.out_valid, bus0.out_data);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_holding_slot();
    test_sync_abort();
    test_sync_with_accept();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
